// File: rtl/accel_avg_filter_pkg.sv
// Shared definitions for the accelerometer moving-average filter:
// word/sum widths, default window depth and FSM state encoding.
package accel_avg_filter_pkg;

    localparam int WORD_W             = 16;
    localparam int LOG2_DEPTH_DEFAULT = 3;
    localparam int DEPTH_DEFAULT      = 1 << LOG2_DEPTH_DEFAULT;
    localparam int SUM_W_DEFAULT      = WORD_W + LOG2_DEPTH_DEFAULT;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Running sum of 2^log2_depth signed words never exceeds this width.
    function automatic int sum_width(input int log2_depth);
        return WORD_W + log2_depth;
    endfunction

endpackage

// File: rtl/accel_avg_filter_axis_ring_avg.sv
// One axis of the moving average: ring buffer, running sum, and the
// average the sum will have once the current sample is committed.
module axis_ring_avg
    import accel_avg_filter_pkg::*;
#(
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tick,
    input  logic [LOG2_DEPTH-1:0] i_wr_ptr,
    input  logic [WORD_W-1:0]     i_sample,
    output logic [WORD_W-1:0]     o_next_avg
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = sum_width(LOG2_DEPTH);

    logic        [WORD_W-1:0] r_buf [DEPTH];
    logic signed [SUM_W-1:0]  r_sum;
    logic signed [SUM_W-1:0]  w_new_ext;
    logic signed [SUM_W-1:0]  w_old_ext;
    logic signed [SUM_W-1:0]  w_next_sum;
    logic        [WORD_W-1:0] w_old;

    assign w_old      = r_buf[i_wr_ptr];
    assign w_new_ext  = {{LOG2_DEPTH{i_sample[WORD_W-1]}}, i_sample};
    assign w_old_ext  = {{LOG2_DEPTH{w_old[WORD_W-1]}}, w_old};
    assign w_next_sum = r_sum + w_new_ext - w_old_ext;

    // Taking this slice is the arithmetic right shift by LOG2_DEPTH, truncated to a word.
    assign o_next_avg = w_next_sum[LOG2_DEPTH +: WORD_W];

    // NOTE: the buffer is reset on purpose; the running sum is only exact if
    // every slot it subtracts starts at zero, so this cannot be left to chance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_sum <= '0;
        end else if (i_tick) begin
            r_buf[i_wr_ptr] <= i_sample;
            r_sum           <= w_next_sum;
        end
    end

endmodule

// File: rtl/accel_avg_filter.sv
// Samples raw X/Y accelerometer words at a fixed rate and emits the
// sliding-window mean per axis with a one-cycle valid strobe.
module accel_avg_filter
    import accel_avg_filter_pkg::*;
#(
    parameter int SAMPLE_DIV = 120000,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] x_axis,
    input  logic [WORD_W-1:0] y_axis,
    output logic [WORD_W-1:0] x_filt,
    output logic [WORD_W-1:0] y_filt,
    output logic              filt_valid,
    output logic              filled
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0]      r_cnt;
    logic                  w_tick;
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_fill;
    state_t                r_state;
    state_t                w_next_state;
    logic                  w_issue;
    logic [WORD_W-1:0]     w_x_avg;
    logic [WORD_W-1:0]     w_y_avg;
    logic [WORD_W-1:0]     r_x_filt;
    logic [WORD_W-1:0]     r_y_filt;
    logic                  r_valid;
    logic                  r_filled;

    assign w_tick = (r_cnt == CNT_W'(SAMPLE_DIV - 1));

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_state  <= ST_FILL;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_state <= w_next_state;
            if (w_tick) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_state == ST_FILL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    // NOTE: defaults come first so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_tick && (r_fill == '1)) begin
                    w_next_state = ST_RUN;
                    w_issue      = 1'b1;
                end
            end
            ST_RUN: begin
                w_issue = w_tick;
            end
            default: w_next_state = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_filt <= '0;
            r_y_filt <= '0;
            r_valid  <= 1'b0;
            r_filled <= 1'b0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_x_filt <= w_x_avg;
                r_y_filt <= w_y_avg;
                r_filled <= 1'b1;
            end
        end
    end

    axis_ring_avg #(.LOG2_DEPTH(LOG2_DEPTH)) u_x_avg (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (w_tick),
        .i_wr_ptr   (r_wr_ptr),
        .i_sample   (x_axis),
        .o_next_avg (w_x_avg)
    );

    axis_ring_avg #(.LOG2_DEPTH(LOG2_DEPTH)) u_y_avg (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (w_tick),
        .i_wr_ptr   (r_wr_ptr),
        .i_sample   (y_axis),
        .o_next_avg (w_y_avg)
    );

    assign x_filt     = r_x_filt;
    assign y_filt     = r_y_filt;
    assign filt_valid = r_valid;
    assign filled     = r_filled;

endmodule

// File: tb/tb_accel_avg_filter.sv
// Self-checking bench for accel_avg_filter: directed and random windows
// compared against a queue-based mean model, checked every clock cycle.
module tb_accel_avg_filter;

    localparam int SAMPLE_DIV = 4;
    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 1 << LOG2_DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] x_axis = '0;
    logic [15:0] y_axis = '0;
    logic [15:0] x_filt;
    logic [15:0] y_filt;
    logic        filt_valid;
    logic        filled;

    int errors = 0;
    int checks = 0;

    // Reference model state: sliding windows of signed samples.
    int          qx[$];
    int          qy[$];
    int          ntick = 0;
    int          pc    = 0;
    logic [15:0] exp_x = '0;
    logic [15:0] exp_y = '0;

    always #5 clk = ~clk;

    accel_avg_filter #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_axis     (x_axis),
        .y_axis     (y_axis),
        .x_filt     (x_filt),
        .y_filt     (y_filt),
        .filt_valid (filt_valid),
        .filled     (filled)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Mean rounded toward minus infinity, as a 16-bit two's complement word.
    function automatic logic [15:0] floor_mean(input int s);
        int q;
        q = s / DEPTH;
        if ((s % DEPTH != 0) && (s < 0)) q = q - 1;
        return 16'(q);
    endfunction

    task automatic model_push(input logic [15:0] xv, input logic [15:0] yv);
        int sx;
        int sy;
        qx.push_back(int'($signed(xv)));
        qy.push_back(int'($signed(yv)));
        if (qx.size() > DEPTH) void'(qx.pop_front());
        if (qy.size() > DEPTH) void'(qy.pop_front());
        ntick++;
        if (ntick >= DEPTH) begin
            sx = 0;
            sy = 0;
            foreach (qx[i]) sx += qx[i];
            foreach (qy[i]) sy += qy[i];
            exp_x = floor_mean(sx);
            exp_y = floor_mean(sy);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the posedge.
    task automatic do_cycle(input logic [15:0] xv, input logic [15:0] yv);
        bit is_tick;
        x_axis = xv;
        y_axis = yv;
        @(posedge clk);
        pc++;
        is_tick = (pc % SAMPLE_DIV == 0);
        if (is_tick) model_push(xv, yv);
        #1;
        check("filt_valid", {15'd0, filt_valid}, {15'd0, (is_tick && ntick >= DEPTH)});
        check("filled", {15'd0, filled}, {15'd0, (ntick >= DEPTH)});
        check("x_filt", x_filt, exp_x);
        check("y_filt", y_filt, exp_y);
        @(negedge clk);
    endtask

    // Run up to and including the next tick; other cycles carry junk if asked.
    task automatic do_tick(input logic [15:0] xv, input logic [15:0] yv, input bit junk);
        bit done;
        done = 1'b0;
        while (!done) begin
            if ((pc + 1) % SAMPLE_DIV == 0) begin
                do_cycle(xv, yv);
                done = 1'b1;
            end else if (junk) begin
                do_cycle(16'($urandom), 16'($urandom));
            end else begin
                do_cycle(xv, yv);
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle, held three cycles, released at negedge.
    task automatic apply_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_rst_x"}, x_filt, 16'h0000);
        check({tag, "_rst_y"}, y_filt, 16'h0000);
        check({tag, "_rst_valid"}, {15'd0, filt_valid}, 16'h0000);
        check({tag, "_rst_filled"}, {15'd0, filled}, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        qx.delete();
        qy.delete();
        ntick = 0;
        pc    = 0;
        exp_x = '0;
        exp_y = '0;
    endtask

    initial begin
        @(negedge clk);
        apply_reset("init");

        // Constant fill: first valid after tick 8, then every 4 cycles.
        repeat (DEPTH + 3) do_tick(16'h0100, 16'hFF00, 1'b0);
        check("const_x", x_filt, 16'h0100);
        check("const_y", y_filt, 16'hFF00);

        // Step from a zero-filled window.
        apply_reset("step");
        repeat (DEPTH) do_tick(16'h0000, 16'h0000, 1'b0);
        repeat (DEPTH + 2) do_tick(16'h0080, 16'($urandom), 1'b0);
        check("step_x", x_filt, 16'h0080);

        // Rounding toward minus infinity.
        apply_reset("round_neg");
        repeat (DEPTH - 1) do_tick(16'h0000, 16'h0000, 1'b0);
        do_tick(16'hFFFF, 16'h0007, 1'b0);
        check("round_neg_x", x_filt, 16'hFFFF);
        check("round_pos_y", y_filt, 16'h0000);

        // Extremes.
        apply_reset("extreme");
        repeat (DEPTH) do_tick(16'h7FFF, 16'h8000, 1'b0);
        check("max_x", x_filt, 16'h7FFF);
        check("min_y", y_filt, 16'h8000);
        repeat (DEPTH) do_tick(16'h8000, 16'h7FFF, 1'b0);
        check("min_x", x_filt, 16'h8000);
        check("max_y", y_filt, 16'h7FFF);
        for (int i = 0; i < DEPTH; i++) begin
            do_tick((i % 2 == 0) ? 16'h7FFF : 16'h8000, (i % 2 == 0) ? 16'h8000 : 16'h7FFF, 1'b0);
        end
        check("alt_x", x_filt, 16'hFFFF);
        check("alt_y", y_filt, 16'hFFFF);

        // Reset mid-RUN, between ticks; refill must not see old data.
        repeat (3) do_tick(16'h7FFF, 16'h7FFF, 1'b0);
        do_cycle(16'h7FFF, 16'h7FFF);
        apply_reset("midrun");
        repeat (DEPTH) do_tick(16'h0010, 16'hFFF0, 1'b0);
        check("post_rst_x", x_filt, 16'h0010);
        check("post_rst_y", y_filt, 16'hFFF0);

        // Random samples with random junk between ticks.
        for (int i = 0; i < 40; i++) begin
            do_tick(16'($urandom), 16'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
